// File: rtl/aligner_apb_regs_pkg.sv
// Shared definitions for the aligner APB register block: address map,
// register field layouts, IRQ bit positions and the bus FSM states.
package aligner_apb_regs_pkg;

  localparam logic [7:0] CTRL_ADDR   = 8'h00;
  localparam logic [7:0] STATUS_ADDR = 8'h04;
  localparam logic [7:0] IRQEN_ADDR  = 8'hF0;
  localparam logic [7:0] IRQ_ADDR    = 8'hF4;

  localparam int IRQ_W        = 5;
  localparam int IRQ_RX_EMPTY = 0;
  localparam int IRQ_RX_FULL  = 1;
  localparam int IRQ_TX_EMPTY = 2;
  localparam int IRQ_TX_FULL  = 3;
  localparam int IRQ_CNT_MAX  = 4;

  localparam int CTRL_CLR_BIT = 16;

  localparam logic [7:0] CNT_DROP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Full 32-bit image of CTRL as seen on the bus
  typedef struct packed {
    logic [14:0] rsvd_hi;
    logic        clr;
    logic [4:0]  rsvd_mid;
    logic [2:0]  size;
    logic [5:0]  rsvd_lo;
    logic [1:0]  offset;
  } ctrl_t;

  typedef struct packed {
    logic [11:0] rsvd_hi;
    logic [3:0]  tx_lvl;
    logic [3:0]  rsvd_mid;
    logic [3:0]  rx_lvl;
    logic [7:0]  cnt_drop;
  } status_t;

  typedef struct packed {
    logic cnt_drop_max;
    logic tx_full;
    logic tx_empty;
    logic rx_full;
    logic rx_empty;
  } irq_t;

  // The aligner can only move naturally aligned 1, 2 or 4 byte lanes
  function automatic logic ctrl_legal(input logic [2:0] size, input logic [1:0] offset);
    logic ok;
    case (size)
      3'd1:    ok = 1'b1;
      3'd2:    ok = (offset[0] == 1'b0);
      3'd4:    ok = (offset == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/aligner_apb_regs_fsm.sv
// APB slave protocol tracker: follows SETUP/ACCESS phases, inserts the
// configured wait states and flags the single completing cycle.
module apb_slave_fsm
  import aligner_apb_regs_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic pclk,
  input  logic preset,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  output logic pready,
  output logic wr_en,
  output logic rd_en
);

  apb_state_e state_q;
  apb_state_e state_d;
  apb_state_e phase;
  logic [2:0] wait_q;
  logic [2:0] wait_d;
  logic       done;

  // The setup cycle is recognised combinationally so that a zero-wait
  // transfer completes in the very first penable cycle.
  always_comb begin
    phase = state_q;
    if (state_q == ST_IDLE && psel && !penable) begin
      phase = ST_SETUP;
    end
  end

  assign done = (phase == ST_ACCESS) && psel && penable && (wait_q == 3'(WAIT_STATES));

  always_comb begin
    state_d = ST_IDLE;
    wait_d  = '0;
    case (phase)
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (done || !psel) begin
          state_d = ST_IDLE;
        end else if (!penable) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_ACCESS;
          wait_d  = wait_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Gating with reset keeps an interrupted transfer from completing
  assign pready = done && !preset;
  assign wr_en  = pready && pwrite;
  assign rd_en  = pready && !pwrite;

endmodule

// File: rtl/aligner_apb_regs.sv
// APB register block for the aligner: CTRL configuration, STATUS readback,
// dropped-word counter and a level interrupt built from IRQ/IRQEN.
module aligner_apb_regs
  import aligner_apb_regs_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic [1:0]            ctrl_offset,
  output logic [2:0]            ctrl_size,
  input  logic                  drop_pulse,
  input  logic [3:0]            rx_lvl,
  input  logic [3:0]            tx_lvl,
  input  logic [3:0]            ev_in,
  output logic                  irq
);

  logic wr_en;
  logic rd_en;

  apb_slave_fsm #(
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .pclk   (pclk),
    .preset (preset),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .pready (pready),
    .wr_en  (wr_en),
    .rd_en  (rd_en)
  );

  logic [1:0]       offset_q;
  logic [2:0]       size_q;
  logic [7:0]       cnt_drop_q;
  logic [IRQ_W-1:0] irqen_q;
  irq_t             irq_q;
  logic             irq_q_out;

  logic             high_zero;
  logic             is_ctrl;
  logic             is_status;
  logic             is_irqen;
  logic             is_irq;
  logic             mapped;
  logic             wr_legal;
  logic             access_err;
  logic             ctrl_we;
  logic             clr;
  logic [IRQ_W-1:0] irq_w1c;
  logic [IRQ_W-1:0] irq_set;
  logic [IRQ_W-1:0] irq_nxt;
  logic [IRQ_W-1:0] irqen_nxt;
  logic             cnt_hits_max;
  logic [31:0]      rd_data;
  ctrl_t            ctrl_img;
  status_t          status_img;
  logic             unused_wdata;

  assign unused_wdata = ^pwdata;

  // Any set bit above the 8-bit register window makes the address unmapped;
  // the map only holds word-aligned entries, so misalignment is also unmapped.
  assign high_zero = ((paddr >> 8) == '0);
  assign is_ctrl   = high_zero && (paddr[7:0] == CTRL_ADDR);
  assign is_status = high_zero && (paddr[7:0] == STATUS_ADDR);
  assign is_irqen  = high_zero && (paddr[7:0] == IRQEN_ADDR);
  assign is_irq    = high_zero && (paddr[7:0] == IRQ_ADDR);
  assign mapped    = is_ctrl || is_status || is_irqen || is_irq;

  assign wr_legal   = ctrl_legal(pwdata[10:8], pwdata[1:0]);
  assign access_err = !mapped
                   || (pwrite && is_status)
                   || (pwrite && is_ctrl && !wr_legal);

  assign ctrl_we = wr_en && is_ctrl && wr_legal;
  assign clr     = ctrl_we && pwdata[CTRL_CLR_BIT];
  assign irq_w1c = (wr_en && is_irq) ? pwdata[IRQ_W-1:0] : '0;

  // Clearing wins over a coincident drop, so no max event can fire then
  assign cnt_hits_max = drop_pulse && !clr && (cnt_drop_q == CNT_DROP_MAX - 8'd1);

  assign irq_set   = {cnt_hits_max, ev_in};
  assign irq_nxt   = (irq_q & ~irq_w1c) | irq_set;
  assign irqen_nxt = (wr_en && is_irqen) ? pwdata[IRQ_W-1:0] : irqen_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      offset_q <= 2'd0;
      size_q   <= 3'd1;
    end else if (ctrl_we) begin
      offset_q <= pwdata[1:0];
      size_q   <= pwdata[10:8];
    end
  end

  always_ff @(posedge pclk) begin
    if (preset || clr) begin
      cnt_drop_q <= '0;
    end else if (drop_pulse && cnt_drop_q != CNT_DROP_MAX) begin
      cnt_drop_q <= cnt_drop_q + 8'd1;
    end
  end

  // irq is computed from next-state values so it trails its cause by one cycle
  always_ff @(posedge pclk) begin
    if (preset) begin
      irq_q     <= '0;
      irqen_q   <= '0;
      irq_q_out <= 1'b0;
    end else begin
      irq_q     <= irq_t'(irq_nxt);
      irqen_q   <= irqen_nxt;
      irq_q_out <= |(irq_nxt & irqen_nxt);
    end
  end

  always_comb begin
    ctrl_img        = '0;
    ctrl_img.size   = size_q;
    ctrl_img.offset = offset_q;

    status_img          = '0;
    status_img.cnt_drop = cnt_drop_q;
    status_img.rx_lvl   = rx_lvl;
    status_img.tx_lvl   = tx_lvl;

    rd_data = '0;
    if (is_ctrl) begin
      rd_data = ctrl_img;
    end else if (is_status) begin
      rd_data = status_img;
    end else if (is_irqen) begin
      rd_data = 32'(irqen_q);
    end else if (is_irq) begin
      rd_data = 32'(irq_q);
    end
  end

  assign prdata      = (rd_en && !access_err) ? DATA_WIDTH'(rd_data) : '0;
  assign pslverr     = pready && access_err;
  assign ctrl_offset = offset_q;
  assign ctrl_size   = size_q;
  assign irq         = irq_q_out;

endmodule

// File: tb/tb_aligner_apb_regs.sv
// Scoreboard bench for aligner_apb_regs: directed register scenarios plus
// randomized bus traffic and sideband events against a behavioural model.
module tb_aligner_apb_regs;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int WS = 2;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;
  logic [1:0]    ctrl_offset;
  logic [2:0]    ctrl_size;
  logic          drop_pulse = 1'b0;
  logic [3:0]    rx_lvl = '0;
  logic [3:0]    tx_lvl = '0;
  logic [3:0]    ev_in = '0;
  logic          irq;

  always #5 pclk = ~pclk;

  aligner_apb_regs #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WAIT_STATES(WS)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr),
    .ctrl_offset(ctrl_offset),
    .ctrl_size  (ctrl_size),
    .drop_pulse (drop_pulse),
    .rx_lvl     (rx_lvl),
    .tx_lvl     (tx_lvl),
    .ev_in      (ev_in),
    .irq        (irq)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];

  // Behavioural register model
  int m_offset;
  int m_size;
  int m_cnt;
  int m_irqen;
  int m_irq;

  function automatic void model_reset();
    m_offset = 0;
    m_size   = 1;
    m_cnt    = 0;
    m_irqen  = 0;
    m_irq    = 0;
  endfunction

  function automatic bit size_offset_ok(int sz, int of);
    if (!(sz == 1 || sz == 2 || sz == 4)) return 1'b0;
    return (of % sz == 0) && (of + sz <= 4);
  endfunction

  function automatic void model_expect(input bit wr, input logic [15:0] addr,
                                       input logic [31:0] data,
                                       output bit err, output logic [31:0] rd);
    bit mapped;
    mapped = (addr == 16'h0000) || (addr == 16'h0004) || (addr == 16'h00F0) || (addr == 16'h00F4);
    err = !mapped || (wr && addr == 16'h0004)
       || (wr && addr == 16'h0000 && !size_offset_ok(int'(data[10:8]), int'(data[1:0])));
    rd = 32'h0;
    if (!err && !wr) begin
      if (addr == 16'h0000)      rd = 32'(m_size * 256 + m_offset);
      else if (addr == 16'h0004) rd = 32'(m_cnt + int'(rx_lvl) * 256 + int'(tx_lvl) * 65536);
      else if (addr == 16'h00F0) rd = 32'(m_irqen);
      else                       rd = 32'(m_irq);
    end
  endfunction

  // One clock edge worth of register effects: bus write first, then events
  function automatic void model_edge(input bit clr, input int w1c, input bit drop, input int ev);
    m_irq = m_irq & ~w1c;
    if (clr) begin
      m_cnt = 0;
    end else if (drop && m_cnt < 255) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == 255) m_irq = m_irq | 16;
    end
    m_irq = m_irq | ev;
  endfunction

  function automatic bit model_irq_line();
    return (m_irq & m_irqen) != 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkSideband();
    checkOutput("ctrl_offset", 32'(ctrl_offset), 32'(m_offset));
    checkOutput("ctrl_size", 32'(ctrl_size), 32'(m_size));
    checkOutput("irq", 32'(irq), 32'(model_irq_line()));
  endtask

  // Full APB transfer; drop/ev are pulsed in the completing cycle
  task automatic applyStimulus(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                               input bit done_drop, input logic [3:0] done_ev);
    bit err;
    logic [31:0] rd;
    int waits;
    bit clr;
    int w1c;
    model_expect(wr, addr, data, err, rd);
    exp_q.push_back({err, rd});
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    while (1) begin
      @(negedge pclk);
      if (pready === 1'b1) break;
      waits++;
      if (waits > 20) break;
    end
    if (pready === 1'b1) begin
      drop_pulse = done_drop;
      ev_in = done_ev;
    end
    checkOutput("wait_states", 32'(waits), 32'(WS));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; drop_pulse = 1'b0; ev_in = '0;
    clr = 1'b0;
    w1c = 0;
    if (!err && wr) begin
      if (addr == 16'h0000) begin
        m_size = int'(data[10:8]);
        m_offset = int'(data[1:0]);
        clr = data[16];
      end else if (addr == 16'h00F0) begin
        m_irqen = int'(data[4:0]);
      end else if (addr == 16'h00F4) begin
        w1c = int'(data[4:0]);
      end
    end
    model_edge(clr, w1c, done_drop, int'(done_ev));
    checkSideband();
  endtask

  task automatic pulseEvents(input bit drop, input logic [3:0] ev);
    @(posedge pclk); #1;
    drop_pulse = drop; ev_in = ev;
    @(posedge pclk); #1;
    drop_pulse = 1'b0; ev_in = '0;
    model_edge(1'b0, 0, drop, int'(ev));
    checkOutput("irq_after_event", 32'(irq), 32'(model_irq_line()));
  endtask

  task automatic resetDut();
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    model_reset();
    checkSideband();
  endtask

  // Monitor: pops an expectation on every completing cycle, otherwise
  // requires the read data and error outputs to stay quiet.
  initial begin
    logic [32:0] exp;
    forever begin
      @(negedge pclk);
      vectors++;
      if (pready === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_pready: got pready=1, expected no transfer at %0t", $time);
        end else begin
          exp = exp_q.pop_front();
          if ({pslverr, prdata} !== exp) begin
            miscompares++;
            $display("[TB] FAIL apb_response: got err=%0b data=0x%08h, expected err=%0b data=0x%08h at %0t",
                     pslverr, prdata, exp[32], exp[31:0], $time);
          end
        end
      end else if (pready !== 1'b0 || prdata !== '0 || pslverr !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_outputs: got pready=%b err=%b data=0x%08h, expected 0/0/0 at %0t",
                 pready, pslverr, prdata, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] addr_pool[10];
    logic [15:0] addr;
    logic [31:0] data;
    addr_pool = '{16'h0000, 16'h0004, 16'h00F0, 16'h00F4, 16'h0008,
                  16'h0002, 16'h00F1, 16'h0100, 16'h01F0, 16'h0080};
    model_reset();
    resetDut();

    // Reset values through the bus
    applyStimulus(1'b0, 16'h0000, 32'h0, 1'b0, 4'h0);
    applyStimulus(1'b0, 16'h00F4, 32'h0, 1'b0, 4'h0);

    // CTRL legality
    applyStimulus(1'b1, 16'h0000, 32'h0000_0201, 1'b0, 4'h0);
    applyStimulus(1'b1, 16'h0000, 32'h0000_0402, 1'b0, 4'h0);
    applyStimulus(1'b1, 16'h0000, 32'h0000_0202, 1'b0, 4'h0);
    applyStimulus(1'b0, 16'h0000, 32'h0, 1'b0, 4'h0);
    applyStimulus(1'b1, 16'h0000, 32'hFFFF_F8FC | 32'h0000_0100, 1'b0, 4'h0);
    applyStimulus(1'b0, 16'h0000, 32'h0, 1'b0, 4'h0);

    // Drop counter saturation and interrupt path
    for (int i = 0; i < 260; i++) pulseEvents(1'b1, 4'h0);
    applyStimulus(1'b0, 16'h0004, 32'h0, 1'b0, 4'h0);
    applyStimulus(1'b0, 16'h00F4, 32'h0, 1'b0, 4'h0);
    applyStimulus(1'b1, 16'h00F0, 32'h0000_0010, 1'b0, 4'h0);
    applyStimulus(1'b1, 16'h00F4, 32'h0000_0010, 1'b0, 4'h0);
    applyStimulus(1'b1, 16'h0000, 32'h0001_0202, 1'b0, 4'h0);
    applyStimulus(1'b0, 16'h0004, 32'h0, 1'b0, 4'h0);

    // Set beats W1C, clear beats drop
    applyStimulus(1'b1, 16'h00F0, 32'h0000_001F, 1'b0, 4'h0);
    pulseEvents(1'b0, 4'b0001);
    applyStimulus(1'b1, 16'h00F4, 32'h0000_0001, 1'b0, 4'b0001);
    applyStimulus(1'b0, 16'h00F4, 32'h0, 1'b0, 4'h0);
    pulseEvents(1'b1, 4'h0);
    applyStimulus(1'b1, 16'h0000, 32'h0001_0100, 1'b1, 4'h0);
    applyStimulus(1'b0, 16'h0004, 32'h0, 1'b0, 4'h0);

    // Error responses
    applyStimulus(1'b1, 16'h0004, 32'hFFFF_FFFF, 1'b0, 4'h0);
    applyStimulus(1'b0, 16'h0008, 32'h0, 1'b0, 4'h0);
    applyStimulus(1'b0, 16'h0002, 32'h0, 1'b0, 4'h0);

    // Reset in the middle of an access phase
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h0000_0203;
    @(posedge pclk); #1;
    penable = 1'b1;
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    model_reset();
    checkSideband();
    applyStimulus(1'b0, 16'h0000, 32'h0, 1'b0, 4'h0);

    // Randomized traffic with interleaved sideband events
    for (int t = 0; t < 150; t++) begin
      rx_lvl = 4'($urandom);
      tx_lvl = 4'($urandom);
      for (int p = 0; p < int'($urandom_range(0, 3)); p++) begin
        pulseEvents($urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
      end
      addr = addr_pool[$urandom_range(0, 9)];
      data = $urandom;
      if ($urandom_range(0, 1) == 1) data = data & 32'h0001_0703;
      applyStimulus($urandom_range(0, 1) == 1, addr, data,
                    $urandom_range(0, 3) == 0, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end

    repeat (3) @(posedge pclk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
